// File: rtl/simplebus_ram_bridge.sv
// Bridges a single-outstanding valid/ready memory request onto the 64-bit RAM helper's
// word-indexed read/write ports, sequencing its one-cycle read latency.
`timescale 1ns/1ps
module simplebus_ram_bridge #(
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] RAM_BASE  = 32'h8000_0000,
    parameter logic [ADDR_W-1:0] RAM_BYTES = 32'h0800_0000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic              req_cmd,
    input  logic [7:0]        req_wmask,
    input  logic [63:0]       req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [63:0]       resp_rdata,
    output logic              resp_err,
    output logic              resp_cmd,
    output logic [63:0]       ram_rIdx,
    input  logic [63:0]       ram_rdata,
    output logic [63:0]       ram_wIdx,
    output logic [63:0]       ram_wdata,
    output logic [63:0]       ram_wmask,
    output logic              ram_wen
);

    typedef enum logic [2:0] {IDLE, RD, CAP, WR, RESP} state_t;

    state_t state, next_state;

    // One extra bit so BASE+BYTES at the top of the address space cannot wrap.
    localparam logic [ADDR_W:0] BASE_EXT  = {1'b0, RAM_BASE};
    localparam logic [ADDR_W:0] LIMIT_EXT = {1'b0, RAM_BASE} + {1'b0, RAM_BYTES};

    logic              fire;
    logic              in_range;
    logic [ADDR_W-1:0] offset;
    logic [63:0]       index;
    logic [63:0]       wmask_bits;
    logic              unused_low;

    assign fire       = req_valid & req_ready;
    assign in_range   = ({1'b0, req_addr} >= BASE_EXT) && ({1'b0, req_addr} < LIMIT_EXT);
    assign offset     = req_addr - RAM_BASE;
    assign index      = 64'(offset[ADDR_W-1:3]);
    assign unused_low = ^offset[2:0];

    always_comb begin
        wmask_bits = '0;
        for (int i = 0; i < 8; i++) begin
            wmask_bits[8*i +: 8] = {8{req_wmask[i]}};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        ram_wen    = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (!in_range) begin
                        next_state = RESP;
                    end else if (req_cmd) begin
                        next_state = WR;
                    end else begin
                        next_state = RD;
                    end
                end
            end
            RD:   next_state = CAP;
            CAP:  next_state = RESP;
            WR: begin
                ram_wen    = 1'b1;
                next_state = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Helper-side outputs are loaded at the fire edge so they are already valid in RD/WR.
    always_ff @(posedge clk) begin
        if (reset) begin
            resp_rdata <= '0;
            resp_err   <= 1'b0;
            resp_cmd   <= 1'b0;
            ram_rIdx   <= '0;
            ram_wIdx   <= '0;
            ram_wdata  <= '0;
            ram_wmask  <= '0;
        end else begin
            if (fire) begin
                resp_cmd   <= req_cmd;
                resp_err   <= ~in_range;
                resp_rdata <= '0;
                if (in_range && !req_cmd) begin
                    ram_rIdx <= index;
                end
                if (in_range && req_cmd) begin
                    ram_wIdx  <= index;
                    ram_wdata <= req_wdata;
                    ram_wmask <= wmask_bits;
                end
            end
            if (state == CAP) begin
                resp_rdata <= ram_rdata;
            end
        end
    end

endmodule
